// File: rtl/counter_4bit.sv
// counter_4bit: loadable up-counter with asynchronous clear, synchronous
// preset, synchronous parallel load and a combinational terminal-count flag.
// At each rising clk edge the priority is preset, then load, then increment.
// The count wraps from all ones back to zero.
module counter_4bit #(
  parameter int unsigned WIDTH = 4  // legal range 2..32
) (
  input  logic             clk,
  input  logic             ret,   // asynchronous active-high clear
  input  logic [WIDTH-1:0] a,     // parallel load value
  input  logic             load,  // synchronous load enable
  input  logic             pre,   // synchronous preset to all ones
  output logic [WIDTH-1:0] y,     // registered count
  output logic             tc     // terminal count: y is all ones
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Count register: clear wins, then preset, then load, then increment.
  always_ff @(posedge clk or posedge ret) begin
    // NOTE: state is assigned with <= so every flop samples the values
    // from before the edge; a blocking = here can cause simulation races
    // and can also make simulation disagree with synthesis.
    if (ret) begin
      y <= '0;
    end else if (pre) begin
      y <= ALL_ONES;
    end else if (load) begin
      y <= a;
    end else begin
      y <= y + 1'b1;  // modulo 2^WIDTH: all ones wraps to zero
    end
  end

  // Terminal-count decode: no register, so there is no added latency.
  always_comb begin
    // NOTE: === makes an unknown y (before the first reset) decode as 0.
    // A plain == would return X there. Synthesis treats === as ==.
    tc = (y === ALL_ONES);
  end

endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: directed scenarios plus randomized stimulus, checked
// against an arithmetic reference model of the counter. The bench covers
// a 4-bit instance and an 8-bit instance.
module tb_counter_4bit;

  logic       clk = 1'b0;
  logic       ret;
  logic       load;
  logic       pre;
  logic [3:0] a4;
  logic [7:0] a8;
  logic [3:0] y4;
  logic [7:0] y8;
  logic       tc4;
  logic       tc8;

  int errors = 0;
  int checks = 0;

  // Reference state, held as plain integers.
  int m4;
  int m8;

  counter_4bit #(.WIDTH(4)) dut4 (
    .clk(clk), .ret(ret), .a(a4), .load(load), .pre(pre), .y(y4), .tc(tc4)
  );

  counter_4bit #(.WIDTH(8)) dut8 (
    .clk(clk), .ret(ret), .a(a8), .load(load), .pre(pre), .y(y8), .tc(tc8)
  );

  // Period 20, first rising edge at t=10.
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Next value computed from the rules: clear, preset, load, then increment mod 2^w.
  function automatic int model_next(int cur, bit r, bit p, bit l, int av, int w);
    int mask = (1 << w) - 1;
    if (r)      return 0;
    else if (p) return mask;
    else if (l) return av & mask;
    else        return (cur + 1) % (1 << w);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_y4"},  32'(y4),  32'(m4));
    check({tag, "_tc4"}, 32'(tc4), 32'(m4 == 15));
    check({tag, "_y8"},  32'(y8),  32'(m8));
    check({tag, "_tc8"}, 32'(tc8), 32'(m8 == 255));
  endtask

  // Advance one rising edge. The model is updated with the inputs seen
  // at that edge, and the outputs are compared 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    m4 = model_next(m4, ret, pre, load, int'(a4), 4);
    m8 = model_next(m8, ret, pre, load, int'(a8), 8);
    #1;
    compare_all(tag);
  endtask

  // Raise ret between edges and check that it clears with no clock edge.
  task automatic async_clear(input string tag);
    ret = 1'b1;
    m4  = 0;
    m8  = 0;
    #1;
    compare_all(tag);
  endtask

  initial begin
    ret  = 1'b1;
    load = 1'b0;
    pre  = 1'b0;
    a4   = '0;
    a8   = '0;
    m4   = 0;
    m8   = 0;
    #1;
    compare_all("reset");

    // Load 1, then count up one step per edge.
    #1;
    ret  = 1'b0;
    a4   = 4'h1;
    a8   = 8'h01;
    load = 1'b1;
    tick("load1");
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("count");  // reaches 5

    // Async clear midway between edges, then hold it against pre and load.
    #8;
    async_clear("async");
    pre  = 1'b1;
    load = 1'b1;
    for (int i = 0; i < 3; i++) tick("ret_hold");
    ret  = 1'b0;
    pre  = 1'b0;
    load = 1'b0;

    // Wrap: load 1101, then step to 1110, 1111, 0000 and 0001.
    a4   = 4'hD;
    load = 1'b1;
    tick("wrap_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("wrap");

    // Preset hold from 0110, then release.
    a4   = 4'h6;
    load = 1'b1;
    tick("pre_load");
    load = 1'b0;
    pre  = 1'b1;
    for (int i = 0; i < 5; i++) tick("pre_hold");
    pre  = 1'b0;
    tick("pre_rel");

    // Priority: pre over load, then load alone, then ret over pre.
    pre  = 1'b1;
    load = 1'b1;
    a4   = 4'h3;
    tick("prio_pre");
    pre  = 1'b0;
    tick("prio_load");
    #5;
    pre = 1'b1;
    async_clear("prio_ret");
    for (int i = 0; i < 2; i++) tick("prio_ret_hold");
    ret  = 1'b0;
    pre  = 1'b0;
    load = 1'b0;

    // 8-bit wrap: 0xFE -> 0xFF (tc) -> 0x00.
    a8   = 8'hFE;
    load = 1'b1;
    tick("w8_load");
    load = 1'b0;
    tick("w8_ff");
    tick("w8_00");

    // Randomized mix. pre and load are sparse so the counter spends
    // long stretches free-running and wraps often.
    for (int i = 0; i < 400; i++) begin
      pre  = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 7) == 0);
      a4   = 4'($urandom);
      a8   = 8'($urandom);
      if ($urandom_range(0, 39) == 0) async_clear("rnd_async");
      else ret = 1'b0;
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
